// File: rtl/dmem_arb_pkg.sv
// Shared types and port identifiers for the data-memory arbiter.
package dmem_arb_pkg;

  // RR: normal alternation between the ports; LOCK1: port 1 owns the memory.
  typedef enum logic {
    RR    = 1'b0,
    LOCK1 = 1'b1
  } arb_state_t;

  // Port identifiers as stored in the last-grant register.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: one-hot grant from two requests.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // A lone requester wins; on a tie the port not granted most recently wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_gnt == PORT_AUX) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one single-ported data memory between the core
// (port 0) and a secondary bus master (port 1) that may lock bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W      = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W:0]  LOCK_LIMIT = (CNT_W + 1)'(LOCK_MAX);
  // With LOCK_MAX = 1 the initial grant already uses the whole budget, so
  // the locked state is never entered.
  localparam bit              LOCK_EN    = (LOCK_MAX > 1);

  arb_state_t        state_reg, state_next;
  logic              last_gnt_reg, last_gnt_next;
  logic [CNT_W-1:0]  lock_cnt_reg, lock_cnt_next;
  logic [CNT_W:0]    lock_cnt_inc;
  logic [1:0]        req_vec, we_vec, pick, gnt_vec, rd_take;
  logic [1:0]        rvalid_reg;
  logic [DATA_W-1:0] rdata_reg [2];

  assign req_vec      = {req1, req0};
  assign we_vec       = {we1, we0};
  assign lock_cnt_inc = {1'b0, lock_cnt_reg} + (CNT_W + 1)'(1);

  rr_pick2 u_pick (
    .req      (req_vec),
    .last_gnt (last_gnt_reg),
    .gnt      (pick)
  );

  // Next-state and grant logic: round-robin normally, port 1 only while locked.
  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    lock_cnt_next = lock_cnt_reg;
    gnt_vec       = 2'b00;
    case (state_reg)
      RR: begin
        gnt_vec = pick;
        if (pick[0]) begin
          last_gnt_next = PORT_CPU;
        end
        if (pick[1]) begin
          last_gnt_next = PORT_AUX;
          if (lock1 && LOCK_EN) begin
            state_next    = LOCK1;
            lock_cnt_next = CNT_W'(1);
          end
        end
      end
      LOCK1: begin
        // Port 1 keeps the exit cycle; port 0 then wins the next tie.
        gnt_vec       = {req1, 1'b0};
        last_gnt_next = PORT_AUX;
        lock_cnt_next = lock_cnt_inc[CNT_W-1:0];
        if (!lock1 || !req1 || (lock_cnt_inc >= LOCK_LIMIT)) begin
          state_next    = RR;
          lock_cnt_next = '0;
        end
      end
      default: state_next = RR;
    endcase
    if (!reset) begin
      gnt_vec = 2'b00;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= RR;
      last_gnt_reg <= PORT_AUX;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  // Per-port read-capture strobes and output wiring.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign rd_take[gi] = gnt_vec[gi] & ~we_vec[gi];
    end
  endgenerate

  // Read-return registers: capture memory data on a granted read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid_reg <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        rdata_reg[i] <= '0;
      end
    end else begin
      rvalid_reg <= rd_take;
      for (int i = 0; i < 2; i++) begin
        if (rd_take[i]) begin
          rdata_reg[i] <= mem_rdata;
        end
      end
    end
  end

  assign gnt0      = gnt_vec[0];
  assign gnt1      = gnt_vec[1];
  assign rvalid0   = rvalid_reg[0];
  assign rvalid1   = rvalid_reg[1];
  assign rdata0    = rdata_reg[0];
  assign rdata1    = rdata_reg[1];
  assign mem_we    = |(gnt_vec & we_vec);
  assign mem_addr  = gnt_vec[1] ? addr1  : addr0;
  assign mem_wdata = gnt_vec[1] ? wdata1 : wdata0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and a read-data
// scoreboard per port.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int          checks   = 0;
  int          failures = 0;

  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit          pend0, pend1;
  logic [31:0] exp_rd0, exp_rd1;

  dmem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .LOCK_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .lock1     (lock1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
  endfunction

  // Behavioural single-ported memory, reloaded with seed contents in reset.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check grants/mux/read returns, update model.
  task automatic cyc(input string tag, input logic rst,
                     input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic l1, input logic eg0, input logic eg1);
    @(posedge clk);
    #1;
    reset = rst;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    lock1 = l1;
    @(negedge clk);
    check({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
    check({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
    check({tag, ".both"}, 32'(gnt0 & gnt1), 32'd0);
    check({tag, ".mem_we"}, 32'(mem_we), 32'((eg0 & w0) | (eg1 & w1)));
    check({tag, ".mem_addr"}, mem_addr, eg1 ? a1 : a0);
    check({tag, ".mem_wdata"}, mem_wdata, eg1 ? d1 : d0);
    check({tag, ".rvalid0"}, 32'(rvalid0), 32'(pend0));
    check({tag, ".rvalid1"}, 32'(rvalid1), 32'(pend1));
    if (pend0 && q0.size() > 0) exp_rd0 = q0.pop_front();
    if (pend1 && q1.size() > 0) exp_rd1 = q1.pop_front();
    check({tag, ".rdata0"}, rdata0, exp_rd0);
    check({tag, ".rdata1"}, rdata1, exp_rd1);
    $display("%-6s t=%0t rst=%0b g0=%0b g1=%0b we=%0b addr=%h rv0=%0b rd0=%h rv1=%0b rd1=%h",
             tag, $time, rst, gnt0, gnt1, mem_we, mem_addr, rvalid0, rdata0, rvalid1, rdata1);
    pend0 = eg0 && !w0;
    pend1 = eg1 && !w1;
    if (pend0) q0.push_back(exp_mem[a0[9:2]]);
    if (pend1) q1.push_back(exp_mem[a1[9:2]]);
    if (eg0 && w0) exp_mem[a0[9:2]] = d0;
    if (eg1 && w1) exp_mem[a1[9:2]] = d1;
    if (!rst) begin
      pend0 = 1'b0;
      pend1 = 1'b0;
      q0.delete();
      q1.delete();
      exp_rd0 = '0;
      exp_rd1 = '0;
      for (int i = 0; i < 256; i++) exp_mem[i] = seed(i);
    end
  endtask

  initial begin
    reset = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    lock1 = 0;
    pend0 = 0; pend1 = 0;
    exp_rd0 = '0; exp_rd1 = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = seed(i);

    // Reset held low with both ports requesting: no grants, no writes.
    repeat (3) cyc("rst", 0, 1, 0, 32'h10, 0, 1, 1, 32'h20, 32'h55, 1, 0, 0);

    // Single port-0 read of 0x10, data next cycle.
    cyc("rd0", 1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single port-1 read: makes port 1 the most recent winner.
    cyc("rd1", 1, 0, 0, 0, 0, 1, 0, 32'h30, 0, 0, 0, 1);

    // Contention: grants alternate starting with port 0.
    for (int i = 0; i < 6; i++)
      cyc("tie", 1, 1, 0, 32'h40, 0, 1, 0, 32'h44, 0, 0, (i % 2) == 0, (i % 2) == 1);

    // Port-1 write then port-0 read of the same word.
    cyc("wr1", 1, 0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678, 0, 0, 1);
    cyc("rdbk", 1, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Lock held to the limit (4): four port-1 grants, then port 0.
    for (int i = 0; i < 5; i++)
      cyc("lock", 1, 1, 0, 32'h50, 0, 1, 0, 32'h54, 0, 1, i == 4, i < 4);

    // Lock dropped after two locked cycles: exit cycle to port 1, then port 0.
    cyc("drop", 1, 1, 0, 32'h50, 0, 1, 0, 32'h58, 0, 1, 0, 1);
    cyc("drop", 1, 1, 0, 32'h50, 0, 1, 0, 32'h58, 0, 1, 0, 1);
    cyc("drop", 1, 1, 0, 32'h50, 0, 1, 0, 32'h58, 0, 0, 0, 1);
    cyc("drop", 1, 1, 0, 32'h50, 0, 1, 0, 32'h58, 0, 0, 1, 0);
    cyc("rr", 1, 0, 0, 0, 0, 1, 0, 32'h5C, 0, 0, 0, 1);

    // Port 1 releases its request while locked: nobody is granted that cycle.
    cyc("rel", 1, 0, 0, 0, 0, 1, 0, 32'h64, 0, 1, 0, 1);
    cyc("rel", 1, 1, 0, 32'h68, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rel", 1, 1, 0, 32'h68, 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset during a lock: back to round-robin, port-1 read data cleared.
    cyc("mlock", 1, 0, 0, 0, 0, 1, 0, 32'h60, 0, 1, 0, 1);
    cyc("mrst", 0, 1, 0, 32'h6C, 0, 1, 0, 32'h60, 0, 1, 0, 0);
    cyc("post", 1, 1, 0, 32'h6C, 0, 1, 0, 32'h60, 0, 1, 1, 0);
    cyc("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
